// File: rtl/frame_spill_unit.sv
// frame_spill_unit: LIFO spill/refill of 256-bit register frames to a 16-bit memory stack.
// Define FRAME_SPILL_CHECKSUM_EN to append an XOR checksum word per frame and enable chk_err.
module frame_spill_unit #(
  parameter logic [15:0] BASE_ADDR  = 16'hF000,
  parameter int          MAX_FRAMES = 16,
  parameter int          DEPTH_W    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               backup,
  input  logic               restore,
  input  logic [255:0]       frame_in,
  output logic [255:0]       frame_out,
  output logic               frame_valid,
  output logic               busy,
  output logic [DEPTH_W-1:0] depth,
  output logic               overflow,
  output logic               underflow,
  output logic [15:0]        mem_addr,
  output logic [15:0]        mem_wdata,
  output logic               mem_we,
  output logic               mem_re,
  input  logic [15:0]        mem_rdata
`ifdef FRAME_SPILL_CHECKSUM_EN
  ,
  output logic               chk_err
`endif
);

`ifdef FRAME_SPILL_CHECKSUM_EN
  localparam int STRIDE = 17;
`else
  localparam int STRIDE = 16;
`endif
  localparam logic [4:0]         SPILL_LAST = 5'(STRIDE - 1);
  localparam logic [4:0]         FILL_LAST  = 5'(STRIDE);
  localparam logic [15:0]        STRIDE16   = 16'(STRIDE);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX  = DEPTH_W'(MAX_FRAMES);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);

  typedef enum logic [1:0] {IDLE, SPILL, FILL, DONE} state_t;

  state_t             state_q, state_d;
  logic [4:0]         k_q, k_d;
  logic [15:0]        sp_q, sp_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [255:0]       shift_q, shift_d;
  logic [255:0]       asm_q, asm_d;
  logic [255:0]       frameOut_q, frameOut_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
`ifdef FRAME_SPILL_CHECKSUM_EN
  logic [15:0]        sum_q, sum_d;
  logic               chkErr_q, chkErr_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      sp_q        <= BASE_ADDR;
      depth_q     <= '0;
      shift_q     <= '0;
      asm_q       <= '0;
      frameOut_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
`ifdef FRAME_SPILL_CHECKSUM_EN
      sum_q       <= '0;
      chkErr_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      sp_q        <= sp_d;
      depth_q     <= depth_d;
      shift_q     <= shift_d;
      asm_q       <= asm_d;
      frameOut_q  <= frameOut_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
`ifdef FRAME_SPILL_CHECKSUM_EN
      sum_q       <= sum_d;
      chkErr_q    <= chkErr_d;
`endif
    end
  end

  // Memory strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    sp_d        = sp_q;
    depth_d     = depth_q;
    shift_d     = shift_q;
    asm_d       = asm_q;
    frameOut_d  = frameOut_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
`ifdef FRAME_SPILL_CHECKSUM_EN
    sum_d       = sum_q;
    chkErr_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (backup) begin
          if (depth_q != DEPTH_MAX) begin
            shift_d = frame_in;
            k_d     = '0;
            state_d = SPILL;
`ifdef FRAME_SPILL_CHECKSUM_EN
            sum_d   = '0;
`endif
          end else begin
            overflow_d = 1'b1;
          end
        end else if (restore) begin
          if (depth_q != '0) begin
            sp_d    = sp_q - STRIDE16;
            depth_d = depth_q - DEPTH_ONE;
            k_d     = '0;
            state_d = FILL;
`ifdef FRAME_SPILL_CHECKSUM_EN
            sum_d   = '0;
`endif
          end else begin
            underflow_d = 1'b1;
          end
        end
      end
      SPILL: begin
        mem_we    = 1'b1;
        mem_addr  = sp_q + 16'(k_q);
        mem_wdata = shift_q[255:240];
`ifdef FRAME_SPILL_CHECKSUM_EN
        if (k_q == SPILL_LAST) mem_wdata = sum_q;
        sum_d = sum_q ^ shift_q[255:240];
`endif
        shift_d = {shift_q[239:0], 16'h0000};
        k_d     = k_q + 5'd1;
        if (k_q == SPILL_LAST) begin
          sp_d    = sp_q + STRIDE16;
          depth_d = depth_q + DEPTH_ONE;
          k_d     = '0;
          state_d = IDLE;
        end
      end
      FILL: begin
        if (k_q != FILL_LAST) begin
          mem_re   = 1'b1;
          mem_addr = sp_q + 16'(k_q);
        end
        // Read data lags the address by one cycle; shifting in places word 0 at the top.
        if (k_q != 5'd0 && k_q <= 5'd16) begin
          asm_d = {asm_q[239:0], mem_rdata};
`ifdef FRAME_SPILL_CHECKSUM_EN
          sum_d = sum_q ^ mem_rdata;
`endif
        end
        k_d = k_q + 5'd1;
        if (k_q == FILL_LAST) begin
          frameOut_d = asm_d;
          k_d        = '0;
          state_d    = DONE;
`ifdef FRAME_SPILL_CHECKSUM_EN
          chkErr_d   = (sum_q != mem_rdata);
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign frame_out   = frameOut_q;
  assign frame_valid = (state_q == DONE);
  assign busy        = (state_q == SPILL) || (state_q == FILL);
  assign depth       = depth_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
`ifdef FRAME_SPILL_CHECKSUM_EN
  assign chk_err     = chkErr_q;
`endif

endmodule
